inpass_sync_filter_config_mux: RTL and testbench
================================================

// Module: inpass_sync_filter_config_mux
// PURPOSE
//  Parametrised input-pass BEL for RAM_IO/IO tiles: WIDTH independent channels carrying external
//  signals (I) into the fabric (O). Each channel is configured by 2 frame config bits to one of four
//  modes: combinational, registered, 2-flop synchroniser, or synchronised + glitch/debounce filtered.
//  This generalises the 4-channel comb/registered pass BEL to arbitrary width and asynchronous inputs.
// PARAMETERS
//  WIDTH        4            number of channels
//  FILT_LEN     4            debounce length in UserCLK cycles (>=1); sync'd input must differ for this many cycles
//  NoConfigBits 2*WIDTH      config bits; channel i uses ConfigBits[2i+1:2i]
// PORTS
//  UserCLK      in   1               fabric user clock; all flops rise-edge; EXTERNAL, SHARED_PORT
//  resetn       in   1               asynchronous active-low reset; EXTERNAL, SHARED_PORT
//  I            in   WIDTH           external inputs (may be asynchronous to UserCLK); EXTERNAL
//  O            out  WIDTH           to switch matrix
//  ConfigBits   in   NoConfigBits    GLOBAL frame config, static during user operation
// BEHAVIOUR
//  - One clock (UserCLK); reset is asynchronous, active-low (resetn); all flops clear to 0 on resetn=0.
//  - Per channel i, mode m = ConfigBits[2i+1:2i]:
//    00 COMB : O[i] = I[i], zero latency; unaffected by reset.
//    01 REG  : O[i] = s1[i]; s1 <= I each edge; latency 1 edge.
//    10 SYNC : O[i] = s2[i]; s2 <= s1 each edge; latency 2 edges.
//    11 FILT : O[i] = db[i] (debounced s2); latency FILT_LEN+2 edges from I change.
//  - s1/s2 chain always runs regardless of mode; REG shares the first sync flop (no extra flop).
//  - FILT state per channel: db (1b), cnt (clog2(FILT_LEN+1) bits), both reset 0.
//    s2==db            : cnt<=0, db holds.
//    s2!=db, cnt<FILT_LEN-1 : cnt<=cnt+1.
//    s2!=db, cnt==FILT_LEN-1: db<=s2, cnt<=0 (same edge).
//    Any return of s2 to db before threshold clears cnt -> pulses shorter than FILT_LEN cycles are dropped.
//    cnt never exceeds FILT_LEN-1; no wrap. FILT_LEN=1 -> db follows s2 with one extra edge.
//  - Filter state updates every cycle in all modes; switching mode to FILT shows current db immediately.
//  - Reset outputs: COMB channels follow I; REG/SYNC/FILT channels drive 0 while resetn=0 and until
//    new data propagates. resetn deassertion mid-count: cnt restarts from 0, db=0.
//  - resetn asserted mid-operation: flops clear asynchronously in same delta, O of non-COMB channels -> 0.
//  - Output select is a 4:1 mux per channel built from cus_mux21_buf cells (2 levels, S=ConfigBits bits)
//    so the config path matches the tile's characterised mux library.
//  - No cross-channel interaction; channels are identical.
// STRUCTURE
//  - Shared include (inpass_defs.vh): mode constants MODE_COMB=2'b00, MODE_REG=2'b01,
//    MODE_SYNC=2'b10, MODE_FILT=2'b11; clog2 function.
//  - Sub-module inpass_filter_chan (one channel: s1, s2, db, cnt, 4:1 cus_mux21_buf tree), parameter
//    FILT_LEN; top instantiates WIDTH copies in a generate loop and slices ConfigBits.
//  - BelMap attribute lists per-channel mode bits I<i>_mode0/I<i>_mode1 at 2i/2i+1.
// TESTING
//  - Reset: resetn=0, all modes set, I=4'hF -> O=4'h1 pattern per COMB channels only (e.g. cfg 8'hE4:
//    ch0 COMB=1, ch1..3 =0); release -> REG ch after 1 edge, SYNC after 2, FILT after 6 (FILT_LEN=4).
//  - Latency: cfg all REG, I 0->1 between edges -> O=1 after edge 1; all SYNC -> after edge 2.
//  - Glitch reject: FILT, I high for 3 cycles then low -> O stays 0; I high 4 cycles -> O=1 at edge 6.
//  - Chatter: FILT, I toggles 1,1,1,0,1,1,1,1 -> cnt clears on the 0, O rises 4 cycles after last restart.
//  - Async reset mid-count: FILT, cnt=2, pull resetn=0 between edges -> O=0 immediately, cnt=0; re-release,
//    steady I=1 -> O=1 after 6 edges.
//  - Mode switch: ch0 SYNC tracking I=1 for 10 cycles, switch cfg to FILT -> O=1 immediately (db converged);
//    WIDTH=8,FILT_LEN=1 regression -> FILT latency 3 edges on every channel.

Source files
------------

// File: rtl/inpass_sync_filter_config_mux_pkg.sv
// Shared definitions for the input-pass BEL: per-channel mode encoding and a constant log2 helper.
package inpass_sync_filter_config_mux_pkg;

    typedef enum logic [1:0] {
        MODE_COMB = 2'b00,
        MODE_REG  = 2'b01,
        MODE_SYNC = 2'b10,
        MODE_FILT = 2'b11
    } mode_e;

    localparam int unsigned MODE_W = 2;

    // Ceiling log2 for elaboration-time sizing; returns 0 for inputs 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        if (value > 1) begin
            for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cus_mux21_buf.sv
// Buffered 2:1 mux cell from the tile's characterised mux library (behavioural view).
module cus_mux21_buf (
    input  logic A0,
    input  logic A1,
    input  logic S,
    output logic X
);

    assign X = S ? A1 : A0;

endmodule

// File: rtl/inpass_filter_chan.sv
// One input-pass channel: 2-flop synchroniser, debounce filter and a 4:1 mode-select mux tree.
module inpass_filter_chan
    import inpass_sync_filter_config_mux_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic       UserCLK,
    input  logic       resetn,
    input  logic       i_in,
    input  logic [1:0] mode,
    output logic       o_c
);

    localparam int unsigned       CNT_W    = (clog2(FILT_LEN + 1) < 1) ? 1 : clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mux_lo, mux_hi;

    // Sync chain always runs; the filter commits s2 only after FILT_LEN consecutive differing samples.
    always_comb begin
        s1_d  = i_in;
        s2_d  = s1_q;
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    // Two-level select: mode[0] picks within {I,s1} / {s2,db}, mode[1] picks the pair.
    cus_mux21_buf u_mux_lo (
        .A0 (i_in),
        .A1 (s1_q),
        .S  (mode[0]),
        .X  (mux_lo)
    );

    cus_mux21_buf u_mux_hi (
        .A0 (s2_q),
        .A1 (db_q),
        .S  (mode[0]),
        .X  (mux_hi)
    );

    cus_mux21_buf u_mux_out (
        .A0 (mux_lo),
        .A1 (mux_hi),
        .S  (mode[1]),
        .X  (o_c)
    );

endmodule

// File: rtl/inpass_sync_filter_config_mux.sv
// WIDTH-channel input-pass BEL; channel i mode bits I<i>_mode0/I<i>_mode1 sit at ConfigBits[2i]/[2i+1].
module inpass_sync_filter_config_mux
    import inpass_sync_filter_config_mux_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned FILT_LEN     = 4,
    parameter int unsigned NoConfigBits = 2 * WIDTH
) (
    input  logic                    UserCLK,
    input  logic                    resetn,
    input  logic [WIDTH-1:0]        I,
    output logic [WIDTH-1:0]        O,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_chan
        inpass_filter_chan #(
            .FILT_LEN (FILT_LEN)
        ) u_chan (
            .UserCLK (UserCLK),
            .resetn  (resetn),
            .i_in    (I[g]),
            .mode    (ConfigBits[MODE_W*g +: MODE_W]),
            .o_c     (O[g])
        );
    end

endmodule

// File: tb/tb_inpass_sync_filter_config_mux.sv
// Directed bench for the input-pass BEL: vector table plus reset, glitch, chatter and mode-switch sequences.
module tb_inpass_sync_filter_config_mux;
    import inpass_sync_filter_config_mux_pkg::*;

    logic        clk;
    logic        resetn;
    logic [3:0]  I;
    logic [3:0]  O;
    logic [7:0]  cfg;
    logic [7:0]  I8;
    logic [7:0]  O8;
    logic [15:0] cfg8;

    int errors;
    int checks;

    inpass_sync_filter_config_mux #(
        .WIDTH    (4),
        .FILT_LEN (4)
    ) dut (
        .UserCLK    (clk),
        .resetn     (resetn),
        .I          (I),
        .O          (O),
        .ConfigBits (cfg)
    );

    inpass_sync_filter_config_mux #(
        .WIDTH    (8),
        .FILT_LEN (1)
    ) dut8 (
        .UserCLK    (clk),
        .resetn     (resetn),
        .I          (I8),
        .O          (O8),
        .ConfigBits (cfg8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cfg;
        logic [3:0] i;
        logic [3:0] edges;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        I      = 4'h0;
        I8     = 8'h00;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        resetn = 1'b0;
        cfg    = 8'hE4;
        I      = 4'hF;
        cfg8   = 16'h0000;
        I8     = 8'h00;

        // Table: cumulative sequence from a clean, all-zero state with I=0.
        vecs[0]  = '{8'h00, 4'hA, 4'd0, 4'hA};
        vecs[1]  = '{8'h00, 4'h5, 4'd0, 4'h5};
        vecs[2]  = '{8'h55, 4'h5, 4'd0, 4'h0};
        vecs[3]  = '{8'h55, 4'h5, 4'd1, 4'h5};
        vecs[4]  = '{8'h55, 4'h3, 4'd1, 4'h3};
        vecs[5]  = '{8'hAA, 4'h3, 4'd0, 4'h5};
        vecs[6]  = '{8'hAA, 4'h3, 4'd1, 4'h3};
        vecs[7]  = '{8'hAA, 4'hC, 4'd1, 4'h3};
        vecs[8]  = '{8'hAA, 4'hC, 4'd1, 4'hC};
        vecs[9]  = '{8'hFF, 4'hC, 4'd0, 4'h0};
        vecs[10] = '{8'hFF, 4'hC, 4'd1, 4'h0};
        vecs[11] = '{8'hFF, 4'hC, 4'd2, 4'h0};
        vecs[12] = '{8'hFF, 4'hC, 4'd1, 4'hC};
        vecs[13] = '{8'hFF, 4'h0, 4'd5, 4'hC};
        vecs[14] = '{8'hFF, 4'h0, 4'd1, 4'h0};
        vecs[15] = '{8'hE4, 4'hF, 4'd0, 4'h1};
        vecs[16] = '{8'hE4, 4'hF, 4'd1, 4'h3};
        vecs[17] = '{8'hE4, 4'hF, 4'd1, 4'h7};
        vecs[18] = '{8'hE4, 4'hF, 4'd3, 4'h7};
        vecs[19] = '{8'hE4, 4'hF, 4'd1, 4'hF};

        // Held in reset: only the COMB channel passes I.
        #3;
        check("rst_mixed", 8'(O), 8'h01);
        cfg = 8'h00;
        #1;
        check("rst_all_comb", 8'(O), 8'h0F);
        cfg = 8'h55;
        #1;
        check("rst_all_reg", 8'(O), 8'h00);
        cfg = 8'hE4;
        tick();
        check("rst_edge_held", 8'(O), 8'h01);

        // Release: REG after 1 edge, SYNC after 2, FILT after 6.
        resetn = 1'b1;
        tick();
        check("rel_e1", 8'(O), 8'h03);
        tick();
        check("rel_e2", 8'(O), 8'h07);
        tick();
        tick();
        tick();
        check("rel_e5", 8'(O), 8'h07);
        tick();
        check("rel_e6", 8'(O), 8'h0F);

        // Asynchronous assertion between edges clears non-COMB outputs at once.
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_out", 8'(O), 8'h01);

        do_reset();
        for (int k = 0; k < 20; k++) begin
            cfg = vecs[k].cfg;
            I   = vecs[k].i;
            if (vecs[k].edges == 4'd0) begin
                #1;
            end else begin
                for (int e = 0; e < int'(vecs[k].edges); e++) tick();
            end
            check($sformatf("vec%0d", k), 8'(O), 8'(vecs[k].exp));
        end

        // Glitch reject: 3-cycle pulse dropped, 4-cycle level accepted at edge 6.
        do_reset();
        cfg = {4{MODE_FILT}};
        I   = 4'hF;
        for (int e = 0; e < 3; e++) tick();
        I = 4'h0;
        for (int e = 0; e < 10; e++) begin
            tick();
            check($sformatf("glitch_e%0d", e), 8'(O), 8'h00);
        end
        I = 4'hF;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("level_e%0d", e), 8'(O), (e == 6) ? 8'h0F : 8'h00);
        end

        // Chatter: a single low sample restarts the count.
        do_reset();
        cfg = {4{MODE_FILT}};
        for (int e = 1; e <= 10; e++) begin
            I = (e == 4) ? 4'h0 : 4'hF;
            tick();
            if (e == 9)  check("chatter_e9", 8'(O), 8'h00);
            if (e == 10) check("chatter_e10", 8'(O), 8'h0F);
        end

        // Reset mid-count with db=1, then re-converge from scratch.
        do_reset();
        cfg = {4{MODE_FILT}};
        I   = 4'hF;
        for (int e = 0; e < 6; e++) tick();
        check("midcnt_pre_high", 8'(O), 8'h0F);
        I = 4'h0;
        for (int e = 0; e < 4; e++) tick();
        check("midcnt_counting", 8'(O), 8'h0F);
        #2;
        resetn = 1'b0;
        #1;
        check("midcnt_rst_out", 8'(O), 8'h00);
        check("midcnt_rst_cnt", 8'(dut.g_chan[0].u_chan.cnt_q), 8'h00);
        tick();
        #2;
        resetn = 1'b1;
        I      = 4'hF;
        for (int e = 0; e < 5; e++) tick();
        check("midcnt_rel_e5", 8'(O), 8'h00);
        tick();
        check("midcnt_rel_e6", 8'(O), 8'h0F);

        // Mode switch: SYNC converged for 10 cycles, FILT shows db immediately.
        do_reset();
        cfg = {4{MODE_SYNC}};
        I   = 4'h1;
        for (int e = 0; e < 10; e++) tick();
        check("sw_sync", 8'(O), 8'h01);
        cfg = {4{MODE_FILT}};
        #1;
        check("sw_filt", 8'(O), 8'h01);

        // WIDTH=8, FILT_LEN=1: FILT latency is 3 edges on every channel.
        do_reset();
        cfg8 = 16'hFFFF;
        I8   = 8'hA5;
        tick();
        tick();
        check("w8_a5_e2", O8, 8'h00);
        tick();
        check("w8_a5_e3", O8, 8'hA5);
        I8 = 8'h5A;
        tick();
        tick();
        check("w8_5a_e2", O8, 8'hA5);
        tick();
        check("w8_5a_e3", O8, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
